// File: rtl/inst_mem_loader.sv
// Loads instruction words from board switches into the instruction RAM, one word per debounced
// button press, with an auto-incrementing address and a hold signal that freezes PC/IR meanwhile.
module inst_mem_loader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              btn_wr,
    input  logic              btn_clr,
    input  logic [DATA_W-1:0] sw_word,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   word_cnt,
    output logic              full,
    output logic              fetch_hold
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [ADDR_W:0]  DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    // Index 0 is the write button, index 1 the clear button.
    logic [1:0] btn_raw;
    logic [1:0] btn_stable;
    logic [1:0] btn_evt;

    assign btn_raw = {btn_clr, btn_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic             sync1_q, sync1_d;
            logic             sync2_q, sync2_d;
            logic             stable_q, stable_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             evt;

            // The counter only runs while the synchronised level differs from the accepted
            // level; a bounce back to the accepted level therefore restarts it.
            always_comb begin
                sync1_d  = btn_raw[gi];
                sync2_d  = sync1_q;
                stable_d = stable_q;
                cnt_d    = '0;
                evt      = 1'b0;
                if (sync2_q != stable_q) begin
                    if (cnt_q == DEB_LAST) begin
                        stable_d = sync2_q;
                        evt      = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge Rst) begin
                if (Rst) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q  <= sync1_d;
                    sync2_q  <= sync2_d;
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                end
            end

            assign btn_stable[gi] = stable_q;
            assign btn_evt[gi]    = evt;
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic                full_q, full_d;
    logic                clr_pend_q, clr_pend_d;
    logic                wr_evt, clr_evt;
    logic [ADDR_W:0]     cnt_inc;

    assign wr_evt  = btn_evt[0];
    assign clr_evt = btn_evt[1];
    assign cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_cnt_d  = word_cnt_q;
        full_d      = full_q;
        clr_pend_d  = clr_pend_q;
        case (state_q)
            S_IDLE: begin
                if (clr_evt) begin
                    mem_addr_d = '0;
                    word_cnt_d = '0;
                end else if (wr_evt) begin
                    mem_wdata_d = sw_word;
                    mem_req_d   = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                // A clear seen mid-write is remembered and replaces the increment at ack time.
                if (clr_evt) begin
                    clr_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    clr_pend_d = 1'b0;
                    if (clr_pend_q || clr_evt) begin
                        mem_addr_d = '0;
                        word_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        mem_addr_d = mem_addr_q + 1'b1;
                        word_cnt_d = cnt_inc;
                        if (cnt_inc == DEPTH_CNT) begin
                            full_d  = 1'b1;
                            state_d = S_FULL;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_FULL: begin
                if (clr_evt) begin
                    mem_addr_d = '0;
                    word_cnt_d = '0;
                    full_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_cnt_q  <= '0;
            full_q      <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            word_cnt_q  <= word_cnt_d;
            full_q      <= full_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_cnt   = word_cnt_q;
    assign full       = full_q;
    assign fetch_hold = (state_q != S_IDLE) | btn_stable[0] | btn_stable[1];

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: a vector table, hand-written handshake/bounce/reset
// sequences and randomized presses checked against a transaction-level model.
module tb_inst_mem_loader;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          Rst = 1'b1;
    logic          btn_wr = 1'b0;
    logic          btn_clr = 1'b0;
    logic [DW-1:0] sw_word = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [AW:0]   word_cnt;
    logic          full;
    logic          fetch_hold;

    inst_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .DEB_CYCLES(4)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .btn_wr     (btn_wr),
        .btn_clr    (btn_clr),
        .sw_word    (sw_word),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .word_cnt   (word_cnt),
        .full       (full),
        .fetch_hold (fetch_hold)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // RAM side: acknowledge once the request has been visible for ack_delay cycles.
    int ack_delay = 0;
    int req_age   = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack = (req_age >= ack_delay);
            req_age = req_age + 1;
        end else begin
            mem_ack = 1'b0;
            req_age = 0;
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t  wr_log[$];
    int   req_rises = 0;
    logic req_prev  = 1'b0;
    always @(posedge clk) begin
        if (!Rst && mem_req && mem_ack) begin
            wr_log.push_back('{mem_addr, mem_wdata});
        end
        if (mem_req && !req_prev) req_rises <= req_rises + 1;
        req_prev <= mem_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input bit is_clr, input logic [DW-1:0] w);
        sw_word = w;
        if (is_clr) btn_clr = 1'b1;
        else btn_wr = 1'b1;
        repeat (10) @(negedge clk);
        btn_clr = 1'b0;
        btn_wr  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_op(input string tag, input bit is_clr, input logic [DW-1:0] w, input int delay,
                         input bit exp_wr, input int exp_wr_addr, input int exp_addr,
                         input int exp_cnt, input bit exp_full);
        int n0;
        n0 = wr_log.size();
        ack_delay = delay;
        press(is_clr, w);
        check({tag, " nwrites"}, 32'(wr_log.size() - n0), 32'(exp_wr));
        if (exp_wr && wr_log.size() > n0) begin
            check({tag, " wr_addr"}, 32'(wr_log[n0].addr), 32'(exp_wr_addr));
            check({tag, " wr_data"}, wr_log[n0].data, w);
        end
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        check({tag, " word_cnt"}, 32'(word_cnt), 32'(exp_cnt));
        check({tag, " full"}, 32'(full), 32'(exp_full));
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " fetch_hold"}, 32'(fetch_hold), 32'(exp_full));
        $display("[TB] %s %s word=%h delay=%0d -> addr=%0d cnt=%0d full=%0b",
                 tag, is_clr ? "clr" : "wr ", w, delay, mem_addr, word_cnt, full);
    endtask

    typedef struct {
        bit          is_clr;
        logic [31:0] word;
        int          delay;
        bit          exp_wr;
        int          exp_wr_addr;
        int          exp_addr;
        int          exp_cnt;
        bit          exp_full;
    } vec_t;

    vec_t vecs[8];
    int   m_cnt;

    initial begin
        vecs[0] = '{0, 32'h0000_0001, 0, 1, 0, 1, 1, 0};
        vecs[1] = '{0, 32'h0000_0002, 1, 1, 1, 2, 2, 0};
        vecs[2] = '{0, 32'h0000_0003, 0, 1, 2, 3, 3, 0};
        vecs[3] = '{0, 32'h0000_0004, 2, 1, 3, 0, 4, 1};
        vecs[4] = '{0, 32'h0000_0005, 0, 0, 0, 0, 4, 1};
        vecs[5] = '{1, 32'h0000_0000, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{0, 32'hCAFE_0006, 3, 1, 0, 1, 1, 0};
        vecs[7] = '{1, 32'h0000_0000, 0, 0, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst word_cnt", 32'(word_cnt), 32'd0);
        check("rst full", 32'(full), 32'd0);
        check("rst fetch_hold", 32'(fetch_hold), 32'd0);
        Rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle no req", 32'(req_rises), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].is_clr, vecs[i].word, vecs[i].delay,
                  vecs[i].exp_wr, vecs[i].exp_wr_addr, vecs[i].exp_addr,
                  vecs[i].exp_cnt, vecs[i].exp_full);
        end

        // Handshake with a 3-cycle ack delay
        begin
            bit found;
            found = 1'b0;
            ack_delay = 3;
            sw_word = 32'hE3A01005;
            btn_wr = 1'b1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (mem_req) begin
                    found = 1'b1;
                    break;
                end
            end
            check("hs req seen", 32'(found), 32'd1);
            for (int j = 0; j < 3; j++) begin
                check($sformatf("hs req c%0d", j), 32'(mem_req), 32'd1);
                check($sformatf("hs addr c%0d", j), 32'(mem_addr), 32'd0);
                check($sformatf("hs data c%0d", j), mem_wdata, 32'hE3A01005);
                check($sformatf("hs cnt c%0d", j), 32'(word_cnt), 32'd0);
                if (j < 2) @(negedge clk);
            end
            repeat (2) @(negedge clk);
            check("hs cnt after", 32'(word_cnt), 32'd1);
            check("hs addr after", 32'(mem_addr), 32'd1);
            check("hs req after", 32'(mem_req), 32'd0);
            btn_wr = 1'b0;
            repeat (12) @(negedge clk);
            $display("[TB] handshake word=e3a01005 -> addr=%0d cnt=%0d", mem_addr, word_cnt);
        end

        // Clear arriving while the write is waiting for ack
        begin
            int n0;
            n0 = wr_log.size();
            ack_delay = 1000;
            sw_word = 32'h1234_5678;
            btn_wr = 1'b1;
            repeat (10) @(negedge clk);
            btn_wr = 1'b0;
            check("cdr req held", 32'(mem_req), 32'd1);
            press(1'b1, 32'h1234_5678);
            check("cdr req still", 32'(mem_req), 32'd1);
            check("cdr hold", 32'(fetch_hold), 32'd1);
            check("cdr cnt pre", 32'(word_cnt), 32'd1);
            ack_delay = 0;
            repeat (3) @(negedge clk);
            check("cdr nwrites", 32'(wr_log.size() - n0), 32'd1);
            if (wr_log.size() > n0) begin
                check("cdr wr_addr", 32'(wr_log[n0].addr), 32'd1);
                check("cdr wr_data", wr_log[n0].data, 32'h1234_5678);
            end
            check("cdr cnt", 32'(word_cnt), 32'd0);
            check("cdr addr", 32'(mem_addr), 32'd0);
            check("cdr req", 32'(mem_req), 32'd0);
            check("cdr idle", 32'(fetch_hold), 32'd0);
            $display("[TB] clear-during-req -> addr=%0d cnt=%0d", mem_addr, word_cnt);
        end

        // Bouncing write button
        begin
            int r0, n0;
            r0 = req_rises;
            n0 = wr_log.size();
            ack_delay = 0;
            sw_word = 32'hBEEF_0B0B;
            for (int i = 0; i < 10; i++) begin
                btn_wr = ~btn_wr;
                repeat (2) @(negedge clk);
            end
            check("bounce no req", 32'(req_rises - r0), 32'd0);
            btn_wr = 1'b1;
            repeat (10) @(negedge clk);
            btn_wr = 1'b0;
            repeat (12) @(negedge clk);
            check("bounce one req", 32'(req_rises - r0), 32'd1);
            check("bounce nwrites", 32'(wr_log.size() - n0), 32'd1);
            if (wr_log.size() > n0) begin
                check("bounce wr_addr", 32'(wr_log[n0].addr), 32'd0);
                check("bounce wr_data", wr_log[n0].data, 32'hBEEF_0B0B);
            end
            $display("[TB] bounce -> addr=%0d cnt=%0d", mem_addr, word_cnt);
        end

        // Randomized presses against a word-count model
        m_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            bit          is_clr, ew;
            logic [31:0] w;
            int          d, ewa;
            is_clr = ($urandom_range(0, 3) == 0);
            w      = $urandom;
            d      = $urandom_range(0, 3);
            ew     = 1'b0;
            ewa    = 0;
            if (is_clr) begin
                m_cnt = 0;
            end else if (m_cnt < DEPTH) begin
                ew    = 1'b1;
                ewa   = m_cnt % DEPTH;
                m_cnt = m_cnt + 1;
            end
            do_op($sformatf("rnd%0d", i), is_clr, w, d, ew, ewa, m_cnt % DEPTH, m_cnt,
                  m_cnt == DEPTH);
        end

        // Asynchronous reset in the middle of a pending write
        begin
            int r0;
            ack_delay = 1000;
            sw_word = 32'h5A5A_A5A5;
            btn_clr = 1'b1;
            repeat (10) @(negedge clk);
            btn_clr = 1'b0;
            repeat (12) @(negedge clk);
            btn_wr = 1'b1;
            repeat (10) @(negedge clk);
            btn_wr = 1'b0;
            check("armw req", 32'(mem_req), 32'd1);
            #3 Rst = 1'b1;
            #1;
            check("armw mem_req", 32'(mem_req), 32'd0);
            check("armw mem_addr", 32'(mem_addr), 32'd0);
            check("armw mem_wdata", mem_wdata, 32'd0);
            check("armw word_cnt", 32'(word_cnt), 32'd0);
            check("armw full", 32'(full), 32'd0);
            check("armw fetch_hold", 32'(fetch_hold), 32'd0);
            @(negedge clk);
            Rst = 1'b0;
            ack_delay = 0;
            r0 = req_rises;
            repeat (20) @(negedge clk);
            check("armw no req", 32'(req_rises - r0), 32'd0);
            check("armw req idle", 32'(mem_req), 32'd0);
            $display("[TB] reset mid-write -> addr=%0d cnt=%0d", mem_addr, word_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
